// File: rtl/sirv_qspi_target_physical_if.sv
// Pin, control and byte-stream bundle for the QSPI target physical layer.
// The slave modport is the target block; the master modport is whatever
// drives the pins and the handshakes (SPI master plus media layer).
interface sirv_qspi_target_physical_if;
    logic       io_port_sck;
    logic       io_port_cs;
    logic       io_port_dq_0_i;
    logic       io_port_dq_1_i;
    logic       io_port_dq_2_i;
    logic       io_port_dq_3_i;
    logic       io_port_dq_0_o;
    logic       io_port_dq_1_o;
    logic       io_port_dq_2_o;
    logic       io_port_dq_3_o;
    logic       io_port_dq_0_oe;
    logic       io_port_dq_1_oe;
    logic       io_port_dq_2_oe;
    logic       io_port_dq_3_oe;
    logic       io_ctrl_sck_pol;
    logic       io_ctrl_sck_pha;
    logic [1:0] io_ctrl_fmt_proto;
    logic       io_ctrl_fmt_endian;
    logic       io_ctrl_fmt_iodir;
    logic       io_tx_valid;
    logic       io_tx_ready;
    logic [7:0] io_tx_bits;
    logic       io_rx_valid;
    logic [7:0] io_rx_bits;
    logic       io_tx_underrun;
    logic       io_sel;

    modport slave (
        input  io_port_sck, io_port_cs,
        input  io_port_dq_0_i, io_port_dq_1_i, io_port_dq_2_i, io_port_dq_3_i,
        output io_port_dq_0_o, io_port_dq_1_o, io_port_dq_2_o, io_port_dq_3_o,
        output io_port_dq_0_oe, io_port_dq_1_oe, io_port_dq_2_oe, io_port_dq_3_oe,
        input  io_ctrl_sck_pol, io_ctrl_sck_pha, io_ctrl_fmt_proto,
        input  io_ctrl_fmt_endian, io_ctrl_fmt_iodir,
        input  io_tx_valid, io_tx_bits,
        output io_tx_ready,
        output io_rx_valid, io_rx_bits, io_tx_underrun, io_sel
    );

    modport master (
        output io_port_sck, io_port_cs,
        output io_port_dq_0_i, io_port_dq_1_i, io_port_dq_2_i, io_port_dq_3_i,
        input  io_port_dq_0_o, io_port_dq_1_o, io_port_dq_2_o, io_port_dq_3_o,
        input  io_port_dq_0_oe, io_port_dq_1_oe, io_port_dq_2_oe, io_port_dq_3_oe,
        output io_ctrl_sck_pol, io_ctrl_sck_pha, io_ctrl_fmt_proto,
        output io_ctrl_fmt_endian, io_ctrl_fmt_iodir,
        output io_tx_valid, io_tx_bits,
        input  io_tx_ready,
        input  io_rx_valid, io_rx_bits, io_tx_underrun, io_sel
    );
endinterface

// File: rtl/sirv_qspi_target_physical.sv
// QSPI target physical layer: oversamples SCK/CS/DQ in the system clock
// domain and shifts bytes in and out in single, dual or quad mode.
module sirv_qspi_target_physical (
    input  logic                              clock,
    input  logic                              reset,
    sirv_qspi_target_physical_if.slave        bus
);
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_e;

    function automatic logic [7:0] bit_rev(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7 - i];
        return r;
    endfunction

    state_e     state_r, state_next_s;
    logic       sck_meta_r, sck_s_r, sck_d_r;
    logic       cs_meta_r, cs_s_r;
    logic [3:0] dq_meta_r, dq_s_r;
    logic [1:0] fill_r;
    logic       armed_r;
    logic       pol_r, pha_r, endian_r, iodir_r;
    logic [1:0] proto_r;
    logic [2:0] beat_r, last_beat_s;
    logic [7:0] rx_shift_r, rx_next_s, rx_bits_r;
    logic [7:0] tx_shift_r, tx_shifted_s, hold_r;
    logic       hold_full_r, rx_valid_r, underrun_r;
    logic       select_s, deselect_s, edge_s, rising_s, sample_s, shift_s;
    logic       last_s, load_s, load_endian_s, accept_s;
    logic [3:0] dq_o_s, dq_oe_s;

    // Two-flop synchronizers for all bus pins plus the SCK edge-detect copy.
    always_ff @(posedge clock) begin
        if (reset) begin
            sck_meta_r <= 1'b0;  sck_s_r <= 1'b0;  sck_d_r <= 1'b0;
            cs_meta_r  <= 1'b1;  cs_s_r  <= 1'b1;
            dq_meta_r  <= 4'h0;  dq_s_r  <= 4'h0;
        end else begin
            sck_meta_r <= bus.io_port_sck;  sck_s_r <= sck_meta_r;  sck_d_r <= sck_s_r;
            cs_meta_r  <= bus.io_port_cs;   cs_s_r  <= cs_meta_r;
            dq_meta_r  <= {bus.io_port_dq_3_i, bus.io_port_dq_2_i,
                           bus.io_port_dq_1_i, bus.io_port_dq_0_i};
            dq_s_r     <= dq_meta_r;
        end
    end

    // After reset, only a CS seen high through a full sync pipeline re-arms selection.
    always_ff @(posedge clock) begin
        if (reset) begin
            fill_r  <= 2'd0;
            armed_r <= 1'b0;
        end else begin
            if (fill_r != 2'd2) fill_r <= fill_r + 2'd1;
            if (fill_r == 2'd2 && cs_s_r) armed_r <= 1'b1;
        end
    end

    // Selection state register.
    always_ff @(posedge clock) begin
        if (reset) state_r <= ST_IDLE;
        else       state_r <= state_next_s;
    end

    // Next selection state from the synchronized chip select.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:   if (armed_r && !cs_s_r) state_next_s = ST_ACTIVE; else state_next_s = ST_IDLE;
            ST_ACTIVE: if (cs_s_r) state_next_s = ST_IDLE; else state_next_s = ST_ACTIVE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // Per-mode beat count and shift/sample data paths.
    always_comb begin
        last_beat_s  = 3'd7;
        rx_next_s    = {rx_shift_r[6:0], dq_s_r[0]};
        tx_shifted_s = {tx_shift_r[6:0], 1'b0};
        case (proto_r)
            2'd1: begin
                last_beat_s  = 3'd3;
                rx_next_s    = {rx_shift_r[5:0], dq_s_r[1:0]};
                tx_shifted_s = {tx_shift_r[5:0], 2'b00};
            end
            2'd2: begin
                last_beat_s  = 3'd1;
                rx_next_s    = {rx_shift_r[3:0], dq_s_r};
                tx_shifted_s = {tx_shift_r[3:0], 4'b0000};
            end
            default: begin
                last_beat_s  = 3'd7;
                rx_next_s    = {rx_shift_r[6:0], dq_s_r[0]};
                tx_shifted_s = {tx_shift_r[6:0], 1'b0};
            end
        endcase
    end

    // Event decode: selection changes, SCK edge class, byte boundary loads.
    assign select_s      = (state_r == ST_IDLE) && (state_next_s == ST_ACTIVE);
    assign deselect_s    = (state_r == ST_ACTIVE) && (state_next_s == ST_IDLE);
    assign edge_s        = (state_r == ST_ACTIVE) && !cs_s_r && (sck_s_r != sck_d_r);
    assign rising_s      = sck_s_r & ~sck_d_r;
    assign sample_s      = edge_s && (rising_s == !(pol_r ^ pha_r));
    assign shift_s       = edge_s && !sample_s;
    assign last_s        = sample_s && (beat_r == last_beat_s);
    assign load_s        = select_s || last_s;
    assign load_endian_s = select_s ? bus.io_ctrl_fmt_endian : endian_r;
    assign accept_s      = bus.io_tx_valid && !hold_full_r;

    // Transfer format is frozen for the whole selection.
    always_ff @(posedge clock) begin
        if (reset) begin
            pol_r <= 1'b0;  pha_r <= 1'b0;  proto_r <= 2'd0;
            endian_r <= 1'b0;  iodir_r <= 1'b0;
        end else if (select_s) begin
            pol_r    <= bus.io_ctrl_sck_pol;
            pha_r    <= bus.io_ctrl_sck_pha;
            proto_r  <= bus.io_ctrl_fmt_proto;
            endian_r <= bus.io_ctrl_fmt_endian;
            iodir_r  <= bus.io_ctrl_fmt_iodir;
        end
    end

    // Beat counter, receive shift register and received-byte strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            beat_r     <= 3'd0;
            rx_shift_r <= 8'h00;
            rx_valid_r <= 1'b0;
            rx_bits_r  <= 8'h00;
        end else begin
            rx_valid_r <= last_s;
            if (select_s || deselect_s || last_s) beat_r <= 3'd0;
            else if (sample_s)                    beat_r <= beat_r + 3'd1;
            if (sample_s) rx_shift_r <= rx_next_s;
            if (last_s)   rx_bits_r  <= endian_r ? bit_rev(rx_next_s) : rx_next_s;
        end
    end

    // Transmit shift register, holding register and underrun strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_shift_r  <= 8'hFF;
            hold_r      <= 8'h00;
            hold_full_r <= 1'b0;
            underrun_r  <= 1'b0;
        end else begin
            underrun_r <= load_s && !hold_full_r;
            if (load_s)
                tx_shift_r <= hold_full_r ? (load_endian_s ? bit_rev(hold_r) : hold_r) : 8'hFF;
            else if (shift_s && beat_r != 3'd0)
                tx_shift_r <= tx_shifted_s;
            // An accept can only happen while empty, so it always wins over a load.
            if (accept_s) begin
                hold_r      <= bus.io_tx_bits;
                hold_full_r <= 1'b1;
            end else if (load_s) begin
                hold_full_r <= 1'b0;
            end
        end
    end

    // Pin drivers: top bits of the shift register, enabled only while selected.
    always_comb begin
        dq_o_s  = 4'b0000;
        dq_oe_s = 4'b0000;
        if (state_r == ST_ACTIVE) begin
            case (proto_r)
                2'd1: begin
                    dq_o_s  = {2'b00, tx_shift_r[7:6]};
                    dq_oe_s = {2'b00, iodir_r, iodir_r};
                end
                2'd2: begin
                    dq_o_s  = tx_shift_r[7:4];
                    dq_oe_s = {iodir_r, iodir_r, iodir_r, iodir_r};
                end
                default: begin
                    dq_o_s  = {2'b00, tx_shift_r[7], 1'b0};
                    dq_oe_s = 4'b0010;
                end
            endcase
        end else begin
            dq_o_s  = 4'b0000;
            dq_oe_s = 4'b0000;
        end
    end

    assign bus.io_port_dq_0_o  = dq_o_s[0];
    assign bus.io_port_dq_1_o  = dq_o_s[1];
    assign bus.io_port_dq_2_o  = dq_o_s[2];
    assign bus.io_port_dq_3_o  = dq_o_s[3];
    assign bus.io_port_dq_0_oe = dq_oe_s[0];
    assign bus.io_port_dq_1_oe = dq_oe_s[1];
    assign bus.io_port_dq_2_oe = dq_oe_s[2];
    assign bus.io_port_dq_3_oe = dq_oe_s[3];
    assign bus.io_tx_ready     = ~hold_full_r;
    assign bus.io_rx_valid     = rx_valid_r;
    assign bus.io_rx_bits      = rx_bits_r;
    assign bus.io_tx_underrun  = underrun_r;
    assign bus.io_sel          = (state_r == ST_ACTIVE);
endmodule

// File: tb/tb_sirv_qspi_target_physical.sv
// Bench for the QSPI target physical layer: a behavioural SPI master drives
// the pins, received bytes are scoreboarded, read-back bytes are compared
// against a holding-register model.
module tb_sirv_qspi_target_physical;
    localparam int H = 8;   // SCK half period in system clocks

    logic clock = 1'b0;
    logic reset;
    sirv_qspi_target_physical_if bus();

    sirv_qspi_target_physical dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    int         total = 0;
    int         bad   = 0;
    int         und_cnt = 0;
    int         exp_und = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] model_hold[$];
    logic [7:0] mon_exp;
    logic [7:0] mosi[4];
    bit         wr_en[4];
    logic [7:0] wr_val[4];
    logic [3:0] first_rd;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7 - i];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every rx strobe must match the oldest byte sent.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.io_rx_valid) begin
                if (exp_rx.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rx_unexpected: got %02h expected no strobe", bus.io_rx_bits);
                end else begin
                    mon_exp = exp_rx.pop_front();
                    check("rx_byte", 32'(bus.io_rx_bits), 32'(mon_exp));
                end
            end
            if (bus.io_tx_underrun) und_cnt++;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic model_load(output logic [7:0] v);
        if (model_hold.size() > 0) v = model_hold.pop_front();
        else begin
            v = 8'hFF;
            exp_und++;
        end
    endtask

    task automatic write_hold(input logic [7:0] v);
        int t;
        t = 0;
        while (!bus.io_tx_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        check("tx_ready_wait", 32'(bus.io_tx_ready), 32'd1);
        bus.io_tx_valid = 1'b1;
        bus.io_tx_bits  = v;
        @(negedge clock);
        bus.io_tx_valid = 1'b0;
        model_hold.push_back(v);
        check("tx_ready_drop", 32'(bus.io_tx_ready), 32'd0);
    endtask

    task automatic drive_dq(input logic [3:0] c, input int w);
        bus.io_port_dq_0_i = c[0];
        bus.io_port_dq_1_i = (w >= 2) ? c[1] : 1'b0;
        bus.io_port_dq_2_i = (w == 4) ? c[2] : 1'b0;
        bus.io_port_dq_3_i = (w == 4) ? c[3] : 1'b0;
    endtask

    function automatic logic [3:0] read_dq(input int w);
        if (w == 1)      return {3'b000, bus.io_port_dq_1_o};
        else if (w == 2) return {2'b00, bus.io_port_dq_1_o, bus.io_port_dq_0_o};
        else             return {bus.io_port_dq_3_o, bus.io_port_dq_2_o,
                                 bus.io_port_dq_1_o, bus.io_port_dq_0_o};
    endfunction

    function automatic logic [3:0] oe_vec();
        return {bus.io_port_dq_3_oe, bus.io_port_dq_2_oe, bus.io_port_dq_1_oe, bus.io_port_dq_0_oe};
    endfunction

    // One SCK period; the master samples the target's pins at its own sample edge.
    task automatic beat_cycle(input bit pol, input bit pha, input int w,
                              input logic [3:0] chunk, output logic [3:0] rd);
        if (!pha) begin
            drive_dq(chunk, w);
            wait_clk(H);
            rd = read_dq(w);
            bus.io_port_sck = ~pol;
            wait_clk(H);
            bus.io_port_sck = pol;
        end else begin
            bus.io_port_sck = ~pol;
            drive_dq(chunk, w);
            wait_clk(H);
            rd = read_dq(w);
            bus.io_port_sck = pol;
            wait_clk(H);
        end
    endtask

    task automatic xfer(input bit pol, input bit pha, input logic [1:0] proto,
                        input bit endian, input bit iodir, input int n, input int extra);
        int         w, beats;
        bit         drives;
        logic [3:0] exp_oe, chunk, rd;
        logic [7:0] wire_tx, got, cur_exp;
        w      = (proto == 2'd1) ? 2 : (proto == 2'd2) ? 4 : 1;
        beats  = 8 / w;
        drives = (w == 1) || iodir;
        exp_oe = (w == 1) ? 4'b0010 : (!iodir) ? 4'b0000 : (w == 2) ? 4'b0011 : 4'b1111;
        bus.io_ctrl_sck_pol    = pol;
        bus.io_ctrl_sck_pha    = pha;
        bus.io_ctrl_fmt_proto  = proto;
        bus.io_ctrl_fmt_endian = endian;
        bus.io_ctrl_fmt_iodir  = iodir;
        bus.io_port_sck        = pol;
        und_cnt = 0;
        exp_und = 0;
        wait_clk(4);
        bus.io_port_cs = 1'b0;
        model_load(cur_exp);
        wait_clk(H);
        check("sel_on", 32'(bus.io_sel), 32'd1);
        check("oe_on", 32'(oe_vec()), 32'(exp_oe));
        for (int b = 0; b < n; b++) begin
            wire_tx = endian ? rev8(mosi[b]) : mosi[b];
            exp_rx.push_back(mosi[b]);
            got = 8'h00;
            for (int k = 0; k < beats; k++) begin
                chunk = 4'(wire_tx >> (8 - (k + 1) * w));
                if (b == n - 1 && k == beats - 1)
                    check("underrun_count", 32'(und_cnt), 32'(exp_und));
                beat_cycle(pol, pha, w, chunk, rd);
                if (b == 0 && k == 0) first_rd = rd;
                got = 8'((got << w) | 8'(rd));
                if (k == 0 && wr_en[b]) write_hold(wr_val[b]);
            end
            if (drives) check("master_read", 32'(endian ? rev8(got) : got), 32'(cur_exp));
            model_load(cur_exp);
        end
        for (int e = 0; e < extra; e++) beat_cycle(pol, pha, w, 4'(mosi[0] >> (7 - e)), rd);
        wait_clk(H);
        bus.io_port_cs = 1'b1;
        wait_clk(8);
        check("rx_all_seen", 32'(exp_rx.size()), 32'd0);
        exp_rx.delete();
        check("sel_off", 32'(bus.io_sel), 32'd0);
        check("oe_off", 32'(oe_vec()), 32'd0);
        check("tx_ready_idle", 32'(bus.io_tx_ready), 32'(model_hold.size() == 0));
    endtask

    task automatic clear_wr();
        for (int i = 0; i < 4; i++) begin
            wr_en[i]  = 1'b0;
            wr_val[i] = 8'h00;
        end
    endtask

    function automatic logic [19:0] out_vec();
        return {bus.io_port_dq_3_o, bus.io_port_dq_2_o, bus.io_port_dq_1_o, bus.io_port_dq_0_o,
                oe_vec(), bus.io_rx_valid, bus.io_rx_bits,
                bus.io_tx_ready, bus.io_tx_underrun, bus.io_sel};
    endfunction

    localparam logic [19:0] RESET_OUTS = {4'b0000, 4'b0000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rd;
        bit         r_pol, r_pha, r_end, r_dir;
        logic [1:0] r_proto;
        int         r_n;

        reset = 1'b1;
        bus.io_port_sck = 1'b0;  bus.io_port_cs = 1'b1;
        drive_dq(4'h0, 4);
        bus.io_ctrl_sck_pol = 1'b0;  bus.io_ctrl_sck_pha = 1'b0;
        bus.io_ctrl_fmt_proto = 2'd0;  bus.io_ctrl_fmt_endian = 1'b0;  bus.io_ctrl_fmt_iodir = 1'b0;
        bus.io_tx_valid = 1'b0;  bus.io_tx_bits = 8'h00;
        clear_wr();
        wait_clk(4);
        check("reset_state", 32'(out_vec()), 32'(RESET_OUTS));
        reset = 1'b0;
        wait_clk(4);

        // Mode 0, single, MSB first, hold written ahead.
        write_hold(8'h3C);
        mosi[0] = 8'hA5;
        xfer(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1, 0);

        // Mode 3, two bytes, second hold byte written during the first.
        clear_wr();
        write_hold(8'h81);
        mosi[0] = 8'($urandom);  mosi[1] = 8'($urandom);
        wr_en[0] = 1'b1;  wr_val[0] = 8'h7E;
        xfer(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 2, 0);

        // Quad receive only.
        clear_wr();
        mosi[0] = 8'h5A;  mosi[1] = 8'hC3;
        xfer(1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 2, 0);

        // Dual transmit, LSB first.
        clear_wr();
        write_hold(8'h01);
        mosi[0] = 8'($urandom);
        xfer(1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1, 0);
        check("dual_first_beat", 32'(first_rd), 32'h2);

        // Single, no hold bytes: all-ones and underruns.
        clear_wr();
        mosi[0] = 8'($urandom);  mosi[1] = 8'($urandom);
        xfer(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2, 0);

        // Partial byte discarded, then a full byte.
        mosi[0] = 8'h96;
        xfer(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 0, 5);
        xfer(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1, 0);

        // Reset mid-byte, then CS held low must be ignored.
        write_hold(8'h42);
        bus.io_ctrl_sck_pol = 1'b0;  bus.io_ctrl_sck_pha = 1'b0;
        bus.io_ctrl_fmt_proto = 2'd0;  bus.io_ctrl_fmt_endian = 1'b0;
        bus.io_port_sck = 1'b0;
        wait_clk(4);
        bus.io_port_cs = 1'b0;
        wait_clk(H);
        for (int k = 0; k < 3; k++) beat_cycle(1'b0, 1'b0, 1, 4'h1, rd);
        wait_clk(2);
        reset = 1'b1;
        @(negedge clock);
        check("reset_mid_byte", 32'(out_vec()), 32'(RESET_OUTS));
        reset = 1'b0;
        model_hold.delete();
        for (int k = 0; k < 8; k++) beat_cycle(1'b0, 1'b0, 1, 4'h1, rd);
        check("sel_ignored", 32'(bus.io_sel), 32'd0);
        bus.io_port_cs = 1'b1;
        wait_clk(8);

        // Randomized transfers across all modes.
        for (int it = 0; it < 8; it++) begin
            r_pol   = 1'($urandom_range(0, 1));
            r_pha   = 1'($urandom_range(0, 1));
            r_end   = 1'($urandom_range(0, 1));
            r_dir   = 1'($urandom_range(0, 1));
            r_proto = 2'($urandom_range(0, 3));
            r_n     = $urandom_range(1, 3);
            for (int b = 0; b < 4; b++) begin
                mosi[b]   = 8'($urandom);
                wr_en[b]  = 1'($urandom_range(0, 1));
                wr_val[b] = 8'($urandom);
            end
            if ($urandom_range(0, 1) == 1) write_hold(8'($urandom));
            xfer(r_pol, r_pha, r_proto, r_end, r_dir, r_n, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sirv_qspi_target_physical.md
# sirv_qspi_target_physical

SPI/QSPI target-side physical layer: the far end of the `sirv_qspi_physical` master. Oversamples the externally driven SCK, CS and DQ pins in the `clock` domain and shifts bytes in and out in single, dual or quad mode. Received bytes go to the target's media/FIFO layer; transmit bytes arrive over a valid/ready handshake.

## Interface
- No parameters.
- `clock`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `io_port_sck`  in  1  SCK from the master; asynchronous.
- `io_port_cs`  in  1  chip select, active low; asynchronous.
- `io_port_dq_N_i`  in  1  DQ pin input, N=0..3; asynchronous.
- `io_port_dq_N_o` / `io_port_dq_N_oe`  out  1  DQ pin output / output enable, N=0..3.
- `io_ctrl_sck_pol`, `io_ctrl_sck_pha`  in  1  SPI mode.
- `io_ctrl_fmt_proto`  in  2  0=single, 1=dual, 2=quad; 3 is treated as single.
- `io_ctrl_fmt_endian`  in  1  0=MSB first, 1=LSB first.
- `io_ctrl_fmt_iodir`  in  1  dual/quad only: 1=target drives DQ, 0=target receives.
- `io_tx_valid` / `io_tx_ready` / `io_tx_bits`  in/out/in  1/1/8  transmit byte handshake.
- `io_rx_valid`  out  1  one-cycle strobe; `io_rx_bits` is valid in that cycle.
- `io_rx_bits`  out  8  received byte.
- `io_tx_underrun`  out  1  one-cycle strobe: a byte was loaded while the holding register was empty.
- `io_sel`  out  1  synchronized CS is asserted.

## Operation
- **Synchronizers.** SCK, CS and DQ0..3 each pass through a 2-flop synchronizer. Reset values: CS = 1, all others 0. A delayed copy `sck_d` of the synchronized SCK gives edge detection.
- **States.** IDLE (`io_sel`=0) and ACTIVE (`io_sel`=1).
  - IDLE→ACTIVE on synchronized CS falling. In that same cycle:
    - latch pol, pha, proto, endian and iodir;
    - clear `beat`;
    - load `tx_shift`.
  - ACTIVE→IDLE on synchronized CS rising:
    - any partial rx byte is discarded without an `io_rx_valid`;
    - `beat` is cleared and all OEs drop.
- **Edge classification** (only in ACTIVE, only when `sck_s != sck_d`):
  - rising edge = sample edge iff `pol^pha==0`;
  - the other edge is the shift edge.
- **Bits per beat** w = 1/2/4 (single/dual/quad). Beats per byte B = 8/4/2. `beat` counts completed sample edges and wraps at B.
- **Sample edge.** `rx_shift <= {rx_shift[7-w:0], in}`, where in is:
  - single: dq0;
  - dual: {dq1,dq0};
  - quad: {dq3..dq0}.
- **Last beat of a byte** (`beat`==B-1), on its sample edge:
  - next cycle `io_rx_valid`=1 and `io_rx_bits` = shift result, bit-reversed if endian=1;
  - `beat`<=0;
  - `tx_shift` reloads.
- **Shift edge.** `tx_shift <= tx_shift << w` only if `beat`!=0. With beat==0 the first bits already sit on the pins. This rule covers both pha settings and all byte boundaries.
- **TX outputs.**
  - single: dq1_o = `tx_shift[7]`;
  - dual: {dq1,dq0} = `tx_shift[7:6]`;
  - quad: dq3..0 = `tx_shift[7:4]`;
  - unused `_o` bits are 0.
- **TX output enables.**
  - single: dq1_oe = `io_sel`, others 0;
  - dual: dq0/1_oe = `io_sel & iodir`;
  - quad: dq0..3_oe = `io_sel & iodir`.
- **Holding register.**
  - `io_tx_ready` = ~hold_full; accept when valid & ready.
  - A load takes the hold byte (bit-reversed if endian=1) and clears hold_full.
  - If hold is empty at a load: load 0xFF and pulse `io_tx_underrun`.
  - A load and an accept in the same cycle: the load takes the empty path; the accepted byte is stored in hold.
- **Dual/quad with iodir=0.** The tx path still reloads and may pulse underrun. The upper layer ignores underrun in that case.

## Timing
- **Reset values:**
  - all `_o`/`_oe` = 0;
  - `io_rx_valid`=0, `io_rx_bits`=0;
  - `io_tx_ready`=1, `io_tx_underrun`=0, `io_sel`=0;
  - `beat`=0, `tx_shift`=0xFF, hold empty.
- **Reset mid-transfer:** the block returns to IDLE and ignores the bus until CS is seen deasserted and then asserted again.
- **Pin to edge detect:** 3 clocks (2 sync + compare).
- **rx:** `io_rx_valid` asserts 4 clocks after the last sample SCK edge at the pin.
- **tx:** DQ output changes 4 clocks after the shift SCK edge at the pin (3 to detect + 1 register).
- **Usage constraints (not checked by the block):**
  - SCK high and low time ≥ 5 clock periods;
  - CS-to-first-SCK-edge ≥ 5 clocks;
  - SCK must be at its idle level (pol) when CS falls.
- **Write-ahead:** a hold byte written any time before the load cycle is used; the load cycle itself is too late.

## Test plan
- Mode 0, single, MSB-first; hold=0x3C before CS; master sends 0xA5 -> `io_rx_bits`=0xA5 with one `io_rx_valid`; master reads 0x3C on dq1; no underrun.
- Mode 3 (pol=1, pha=1), single, two bytes; 0x81 then 0x7E written in time -> master reads 0x81, 0x7E; rx bytes are correct; both `io_tx_ready` drops are released.
- Quad, iodir=0; master sends 0x5A, 0xC3 -> two rx strobes with those values; all OEs stay 0.
- Dual, iodir=1, endian=1; hold=0x01 -> dq0/1_oe=1 while selected; master sees the LSB-first stream, i.e. first beat {dq1,dq0}=2'b10.
- Single; no hold byte written; 2 bytes clocked -> master reads 0xFF, 0xFF; `io_tx_underrun` pulses twice (at select, after byte 1).
- CS deasserted after 5 bits; then a full byte 0x96 -> no rx strobe for the partial byte; next rx = 0x96; `reset` asserted mid-byte -> every output at its reset value on the next cycle.
